// File: rtl/vc_test_rand_delay_mem_nport_if.sv
// Request/response bundle for the N-port random-delay test memory.
// The master side issues requests and accepts responses; the slave side is the memory.
interface vc_test_rand_delay_mem_nport_if #(
    parameter int p_num_ports  = 2,
    parameter int p_req_nbits  = 77,
    parameter int p_resp_nbits = 45
);
    logic [p_num_ports-1:0]              memreq_val;
    logic [p_num_ports-1:0]              memreq_rdy;
    logic [p_num_ports*p_req_nbits-1:0]  memreq_msg;
    logic [p_num_ports-1:0]              memresp_val;
    logic [p_num_ports-1:0]              memresp_rdy;
    logic [p_num_ports*p_resp_nbits-1:0] memresp_msg;

    modport master (
        output memreq_val, memreq_msg, memresp_rdy,
        input  memreq_rdy, memresp_val, memresp_msg
    );

    modport slave (
        input  memreq_val, memreq_msg, memresp_rdy,
        output memreq_rdy, memresp_val, memresp_msg
    );
endinterface

// File: rtl/vc_test_rand_delay_mem_nport.sv
// N-port test memory: every port holds its request for an LFSR-drawn random delay,
// then accesses the shared storage and returns a response.
// Optional feature macro: VC_TEST_MEM_STATS_EN enables the per-port accept counters on num_reqs.
module vc_test_rand_delay_mem_nport #(
    parameter int          p_num_ports    = 2,
    parameter int          p_mem_nbytes   = 1024,
    parameter int          p_opaque_nbits = 8,
    parameter int          p_addr_nbits   = 32,
    parameter int          p_data_nbits   = 32,
    parameter logic [15:0] p_lfsr_seed    = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_clear,
    input  logic [8*p_num_ports-1:0]      max_delay,
    vc_test_rand_delay_mem_nport_if.slave mem,
    output logic [32*p_num_ports-1:0]     num_reqs
);
    localparam int c_word_nbytes = p_data_nbits / 8;
    localparam int c_len_nbits   = $clog2(c_word_nbytes);
    localparam int c_idx_nbits   = $clog2(p_mem_nbytes) - c_len_nbits;
    localparam int c_num_words   = p_mem_nbytes / c_word_nbytes;
    localparam int c_req_nbits   = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits;
    localparam int c_resp_nbits  = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Each port seeds its own LFSR; a zero seed would lock the LFSR, so it is forced to 1.
    function automatic logic [15:0] port_seed(input int i);
        logic [15:0] s;
        s = p_lfsr_seed ^ 16'(i + 1);
        if (s == 16'd0) s = 16'd1;
        return s;
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // A zero length selects the whole word, otherwise the low len bytes.
    function automatic logic [c_word_nbytes-1:0] len_mask(input logic [c_len_nbits-1:0] len);
        logic [c_word_nbytes-1:0] m;
        for (int b = 0; b < c_word_nbytes; b++) m[b] = (len == '0) || (b < int'(len));
        return m;
    endfunction

    state_e                    state_q    [p_num_ports];
    state_e                    state_d    [p_num_ports];
    logic [7:0]                cnt_q      [p_num_ports];
    logic [7:0]                cnt_d      [p_num_ports];
    logic [15:0]               lfsr_q     [p_num_ports];
    logic [15:0]               lfsr_d     [p_num_ports];
    logic [2:0]                type_q     [p_num_ports];
    logic [2:0]                type_d     [p_num_ports];
    logic [p_opaque_nbits-1:0] opaque_q   [p_num_ports];
    logic [p_opaque_nbits-1:0] opaque_d   [p_num_ports];
    logic [c_len_nbits-1:0]    len_q      [p_num_ports];
    logic [c_len_nbits-1:0]    len_d      [p_num_ports];
    logic [c_idx_nbits-1:0]    idx_q      [p_num_ports];
    logic [c_idx_nbits-1:0]    idx_d      [p_num_ports];
    logic [p_data_nbits-1:0]   data_q     [p_num_ports];
    logic [p_data_nbits-1:0]   data_d     [p_num_ports];
    logic [c_resp_nbits-1:0]   resp_msg_q [p_num_ports];
    logic [c_resp_nbits-1:0]   resp_msg_d [p_num_ports];
    logic                      rdy_en_q;
    logic                      rdy_en_d;

    logic [2:0]                req_type   [p_num_ports];
    logic [p_opaque_nbits-1:0] req_opaque [p_num_ports];
    logic [p_addr_nbits-1:0]   req_addr   [p_num_ports];
    logic [c_len_nbits-1:0]    req_len    [p_num_ports];
    logic [p_data_nbits-1:0]   req_data   [p_num_ports];
    logic [p_num_ports-1:0]    unused_addr;

    logic [p_num_ports-1:0]    accept;
    logic [p_num_ports-1:0]    access;
    logic [p_num_ports-1:0]    wr_en;
    logic [c_word_nbytes-1:0]  wr_mask    [p_num_ports];
    logic [p_data_nbits-1:0]   rd_word    [p_num_ports];
    logic [p_data_nbits-1:0]   resp_data  [p_num_ports];

    logic [p_data_nbits-1:0]   mem_q      [c_num_words];

    // Split each port's request message into its fields and flag the handshake events.
    always_comb begin
        for (int i = 0; i < p_num_ports; i++) begin
            req_data[i]    = mem.memreq_msg[c_req_nbits*i +: p_data_nbits];
            req_len[i]     = mem.memreq_msg[c_req_nbits*i + p_data_nbits +: c_len_nbits];
            req_addr[i]    = mem.memreq_msg[c_req_nbits*i + p_data_nbits + c_len_nbits +: p_addr_nbits];
            req_opaque[i]  = mem.memreq_msg[c_req_nbits*i + p_data_nbits + c_len_nbits + p_addr_nbits +: p_opaque_nbits];
            req_type[i]    = mem.memreq_msg[c_req_nbits*i + p_data_nbits + c_len_nbits + p_addr_nbits + p_opaque_nbits +: 3];
            unused_addr[i] = ^req_addr[i];
            accept[i]      = (state_q[i] == ST_IDLE) && rdy_en_q && mem.memreq_val[i];
            access[i]      = (state_q[i] == ST_DELAY) && (cnt_q[i] == 8'd0);
        end
    end

    // Per-port state register; reset drops any pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_num_ports; i++) state_q[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < p_num_ports; i++) state_q[i] <= state_d[i];
        end
    end

    // Per-port next state: IDLE -> DELAY on accept, DELAY -> RESP when the count runs out,
    // RESP -> IDLE on the response handshake.
    always_comb begin
        for (int i = 0; i < p_num_ports; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE:  if (accept[i]) state_d[i] = ST_DELAY;
                ST_DELAY: if (cnt_q[i] == 8'd0) state_d[i] = ST_RESP;
                ST_RESP:  if (mem.memresp_rdy[i]) state_d[i] = ST_IDLE;
                default:  state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs; ready is held off until the first edge after reset release.
    always_comb begin
        mem.memreq_rdy  = '0;
        mem.memresp_val = '0;
        mem.memresp_msg = '0;
        for (int i = 0; i < p_num_ports; i++) begin
            mem.memreq_rdy[i]  = (state_q[i] == ST_IDLE) && rdy_en_q;
            mem.memresp_val[i] = (state_q[i] == ST_RESP);
            mem.memresp_msg[c_resp_nbits*i +: c_resp_nbits] = resp_msg_q[i];
        end
    end

    // Storage view per port: a higher port sees same-cycle writes from every lower port.
    always_comb begin
        for (int i = 0; i < p_num_ports; i++) begin
            wr_mask[i] = len_mask(len_q[i]);
            wr_en[i]   = access[i] && (type_q[i] == 3'd1);
        end
        for (int i = 0; i < p_num_ports; i++) begin
            rd_word[i] = mem_q[idx_q[i]];
            for (int j = 0; j < i; j++) begin
                if (wr_en[j] && (idx_q[j] == idx_q[i])) begin
                    for (int b = 0; b < c_word_nbytes; b++) begin
                        if (wr_mask[j][b]) rd_word[i][8*b +: 8] = data_q[j][8*b +: 8];
                    end
                end
            end
            for (int b = 0; b < c_word_nbytes; b++) begin
                if (!wr_mask[i][b]) rd_word[i][8*b +: 8] = 8'd0;
            end
            resp_data[i] = (type_q[i] == 3'd0) ? rd_word[i] : '0;
        end
    end

    // Request capture, delay draw, countdown and response formation.
    always_comb begin
        rdy_en_d = 1'b1;
        for (int i = 0; i < p_num_ports; i++) begin
            cnt_d[i]      = cnt_q[i];
            lfsr_d[i]     = lfsr_q[i];
            type_d[i]     = type_q[i];
            opaque_d[i]   = opaque_q[i];
            len_d[i]      = len_q[i];
            idx_d[i]      = idx_q[i];
            data_d[i]     = data_q[i];
            resp_msg_d[i] = resp_msg_q[i];
            if (accept[i]) begin
                type_d[i]   = req_type[i];
                opaque_d[i] = req_opaque[i];
                len_d[i]    = req_len[i];
                idx_d[i]    = req_addr[i][c_len_nbits +: c_idx_nbits];
                data_d[i]   = req_data[i];
                cnt_d[i]    = 8'(lfsr_q[i] % (16'(max_delay[8*i +: 8]) + 16'd1));
                lfsr_d[i]   = lfsr_next(lfsr_q[i]);
            end else if ((state_q[i] == ST_DELAY) && (cnt_q[i] != 8'd0)) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
            if (access[i]) resp_msg_d[i] = {type_q[i], opaque_q[i], len_q[i], resp_data[i]};
        end
    end

    // Datapath registers; LFSRs reload their seeds on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
            for (int i = 0; i < p_num_ports; i++) begin
                cnt_q[i]      <= 8'd0;
                lfsr_q[i]     <= port_seed(i);
                type_q[i]     <= 3'd0;
                opaque_q[i]   <= '0;
                len_q[i]      <= '0;
                idx_q[i]      <= '0;
                data_q[i]     <= '0;
                resp_msg_q[i] <= '0;
            end
        end else begin
            rdy_en_q <= rdy_en_d;
            for (int i = 0; i < p_num_ports; i++) begin
                cnt_q[i]      <= cnt_d[i];
                lfsr_q[i]     <= lfsr_d[i];
                type_q[i]     <= type_d[i];
                opaque_q[i]   <= opaque_d[i];
                len_q[i]      <= len_d[i];
                idx_q[i]      <= idx_d[i];
                data_q[i]     <= data_d[i];
                resp_msg_q[i] <= resp_msg_d[i];
            end
        end
    end

    // Shared storage: clear wins, otherwise writes land in ascending port order so the highest port wins per byte.
    always_ff @(posedge clk) begin
        if (mem_clear) begin
            for (int w = 0; w < c_num_words; w++) mem_q[w] <= '0;
        end else begin
            for (int i = 0; i < p_num_ports; i++) begin
                if (wr_en[i]) begin
                    for (int b = 0; b < c_word_nbytes; b++) begin
                        if (wr_mask[i][b]) mem_q[idx_q[i]][8*b +: 8] <= data_q[i][8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef VC_TEST_MEM_STATS_EN
    logic [31:0] num_reqs_q [p_num_ports];
    logic [31:0] num_reqs_d [p_num_ports];

    // Accept counters, wrapping naturally at 2^32.
    always_comb begin
        for (int i = 0; i < p_num_ports; i++) begin
            num_reqs_d[i] = num_reqs_q[i] + (accept[i] ? 32'd1 : 32'd0);
        end
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_num_ports; i++) num_reqs_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < p_num_ports; i++) num_reqs_q[i] <= num_reqs_d[i];
        end
    end

    // Pack the counters onto the output bus.
    always_comb begin
        num_reqs = '0;
        for (int i = 0; i < p_num_ports; i++) num_reqs[32*i +: 32] = num_reqs_q[i];
    end
`else
    assign num_reqs = '0;
`endif

endmodule

// File: tb/tb_vc_test_rand_delay_mem_nport.sv
// Bench for the N-port random-delay test memory: per-port scoreboards with a shadow
// storage image and an LFSR model predicting each response's data and exact latency.
module tb_vc_test_rand_delay_mem_nport;
    localparam int NP  = 2;
    localparam int REQ = 77;
    localparam int RSP = 45;

    typedef struct {
        logic [31:0] data;
        logic [12:0] hdr;
        int          delay;
        int          acc_cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_clear;
    logic [15:0] max_delay;
    logic [63:0] num_reqs;

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [31:0] shadow [256];
    logic [15:0] lfsr_m [NP];
    int          opq_ctr [NP];
    int          acc_count [NP];
    exp_t        exp_q [NP][$];
    bit          seen [NP];
    int          first_cycle [NP];

    vc_test_rand_delay_mem_nport_if #(.p_num_ports(NP), .p_req_nbits(REQ), .p_resp_nbits(RSP)) mem_if ();

    vc_test_rand_delay_mem_nport #(.p_num_ports(NP)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_clear (mem_clear),
        .max_delay (max_delay),
        .mem       (mem_if),
        .num_reqs  (num_reqs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] model_seed(input int i);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(i + 1);
        if (s == 16'd0) s = 16'd1;
        return s;
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Issue one request on port p (called at a negedge, returns at the negedge after accept).
    task automatic applyStimulus(input int p, input logic [2:0] typ, input logic [31:0] addr,
                                 input logic [1:0] len, input logic [31:0] data, input bit expect_resp);
        int          waited;
        exp_t        e;
        logic [7:0]  opq;
        logic [7:0]  idx;
        logic [31:0] word;
        logic [7:0]  md;
        opq = 8'(opq_ctr[p]);
        opq_ctr[p]++;
        mem_if.memreq_msg[REQ*p +: REQ] = {typ, opq, addr, len, data};
        mem_if.memreq_val[p] = 1'b1;
        waited = 0;
        while (!mem_if.memreq_rdy[p] && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_if.memreq_rdy[p]) begin
            checkOutput("req_accept_timeout", 64'd0, 64'd1);
            mem_if.memreq_val[p] = 1'b0;
            return;
        end
        md      = max_delay[8*p +: 8];
        e.delay = int'(lfsr_m[p] % (16'(md) + 16'd1));
        lfsr_m[p] = model_step(lfsr_m[p]);
        e.acc_cycle = cycle + 1;
        e.hdr   = {typ, opq, len};
        idx     = addr[9:2];
        word    = shadow[idx];
        e.data  = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (len == 2'd0 || b < int'(len)) begin
                if (typ == 3'd0) e.data[8*b +: 8] = word[8*b +: 8];
                if (typ == 3'd1) word[8*b +: 8] = data[8*b +: 8];
            end
        end
        shadow[idx] = word;
        acc_count[p]++;
        @(negedge clk);
        mem_if.memreq_val[p] = 1'b0;
        if (expect_resp) exp_q[p].push_back(e);
    endtask

    task automatic waitDrain(input int p);
        int n;
        n = 0;
        while (exp_q[p].size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[p].size() != 0) begin
            checkOutput("drain_timeout", 64'(exp_q[p].size()), 64'd0);
            exp_q[p].delete();
        end
        @(negedge clk);
    endtask

    task automatic clearShadow();
        for (int w = 0; w < 256; w++) shadow[w] = 32'd0;
    endtask

    for (genvar g = 0; g < NP; g++) begin : g_mon
        // Pop the scoreboard on every response handshake and compare data, header and latency.
        always @(negedge clk) begin
            exp_t        e;
            logic [44:0] m;
            m = mem_if.memresp_msg[RSP*g +: RSP];
            if (mem_if.memresp_val[g]) begin
                if (!seen[g]) begin
                    seen[g]        = 1'b1;
                    first_cycle[g] = cycle;
                end
                if (mem_if.memresp_rdy[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checkOutput("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        checkOutput("resp_data", 64'(m[31:0]), 64'(e.data));
                        checkOutput("resp_hdr", 64'(m[44:32]), 64'(e.hdr));
                        checkOutput("resp_latency", 64'(first_cycle[g] - e.acc_cycle), 64'(1 + e.delay));
                    end
                    seen[g] = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [44:0] held;
        reset                = 1'b1;
        mem_clear            = 1'b0;
        max_delay            = 16'd0;
        mem_if.memreq_val    = '0;
        mem_if.memreq_msg    = '0;
        mem_if.memresp_rdy   = 2'b11;
        for (int i = 0; i < NP; i++) begin
            lfsr_m[i]    = model_seed(i);
            opq_ctr[i]   = 0;
            acc_count[i] = 0;
            seen[i]      = 1'b0;
        end
        clearShadow();
        #2 reset = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_req_rdy", 64'(mem_if.memreq_rdy), 64'd0);
        checkOutput("rst_resp_val", 64'(mem_if.memresp_val), 64'd0);
        checkOutput("rst_resp_msg", {63'd0, |mem_if.memresp_msg}, 64'd0);
        reset = 1'b1;
        #1 checkOutput("rdy_before_first_edge", 64'(mem_if.memreq_rdy), 64'd0);
        @(negedge clk);
        checkOutput("rdy_after_release", 64'(mem_if.memreq_rdy), 64'd3);
        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;

        // Write on port 0, read back on port 1, zero delay.
        applyStimulus(0, 3'd1, 32'h10, 2'd0, 32'h1234_5678, 1'b1);
        waitDrain(0);
        applyStimulus(1, 3'd0, 32'h10, 2'd0, 32'h0, 1'b1);
        waitDrain(1);

        // Same-cycle writes to one word: the higher port wins.
        fork
            applyStimulus(0, 3'd1, 32'h20, 2'd0, 32'hAAAA_AAAA, 1'b1);
            begin #1 applyStimulus(1, 3'd1, 32'h20, 2'd0, 32'h5555_5555, 1'b1); end
        join
        waitDrain(0);
        waitDrain(1);
        applyStimulus(1, 3'd0, 32'h20, 2'd0, 32'h0, 1'b1);
        waitDrain(1);

        // Same-cycle lower-port write and higher-port read of one word.
        fork
            applyStimulus(0, 3'd1, 32'h30, 2'd0, 32'h0BAD_F00D, 1'b1);
            begin #1 applyStimulus(1, 3'd0, 32'h30, 2'd0, 32'h0, 1'b1); end
        join
        waitDrain(0);
        waitDrain(1);

        // Response back-pressure: everything holds while memresp_rdy is low.
        mem_if.memresp_rdy[0] = 1'b0;
        applyStimulus(0, 3'd0, 32'h20, 2'd0, 32'h0, 1'b1);
        @(negedge clk);
        held = mem_if.memresp_msg[44:0];
        for (int k = 0; k < 10; k++) begin
            checkOutput("hold_val", 64'(mem_if.memresp_val[0]), 64'd1);
            checkOutput("hold_msg", 64'(mem_if.memresp_msg[44:0]), 64'(held));
            checkOutput("hold_req_rdy", 64'(mem_if.memreq_rdy[0]), 64'd0);
            @(negedge clk);
        end
        mem_if.memresp_rdy[0] = 1'b1;
        waitDrain(0);

        // mem_clear wipes a written word.
        applyStimulus(0, 3'd1, 32'h40, 2'd0, 32'hCAFE_BABE, 1'b1);
        waitDrain(0);
        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;
        clearShadow();
        applyStimulus(0, 3'd0, 32'h40, 2'd0, 32'h0, 1'b1);
        waitDrain(0);

        // Partial-length writes/reads and an unsupported type.
        applyStimulus(1, 3'd1, 32'h50, 2'd0, 32'h1234_5678, 1'b1);
        applyStimulus(1, 3'd1, 32'h50, 2'd1, 32'h0000_00FF, 1'b1);
        applyStimulus(1, 3'd0, 32'h50, 2'd0, 32'h0, 1'b1);
        applyStimulus(1, 3'd0, 32'h50, 2'd2, 32'h0, 1'b1);
        applyStimulus(1, 3'd3, 32'h50, 2'd0, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1, 3'd0, 32'h53, 2'd0, 32'h0, 1'b1);
        waitDrain(1);

        // Random traffic on disjoint word ranges with delays up to 8.
        max_delay = {8'd8, 8'd8};
        fork
            for (int k = 0; k < 100; k++) begin
                logic [31:0] a;
                a = $urandom;
                a[9:2] = 8'($urandom_range(0, 63));
                applyStimulus(0, 3'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom, 1'b1);
            end
            for (int k = 0; k < 100; k++) begin
                logic [31:0] a;
                a = $urandom;
                a[9:2] = 8'($urandom_range(64, 127));
                applyStimulus(1, 3'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom, 1'b1);
            end
        join
        waitDrain(0);
        waitDrain(1);

        // Reset while port 0 is in DELAY: the request is dropped and the LFSR restarts.
        max_delay = {8'd8, 8'd200};
        applyStimulus(0, 3'd0, 32'h10, 2'd0, 32'h0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < NP; i++) begin
            lfsr_m[i]    = model_seed(i);
            acc_count[i] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("midrst_req_rdy", 64'(mem_if.memreq_rdy), 64'd0);
            checkOutput("midrst_resp_val", 64'(mem_if.memresp_val), 64'd0);
            checkOutput("midrst_resp_msg", {63'd0, |mem_if.memresp_msg}, 64'd0);
        end
        reset = 1'b1;
        #1 checkOutput("midrst_rdy_before_edge", 64'(mem_if.memreq_rdy), 64'd0);
        @(negedge clk);
        checkOutput("midrst_rdy_after_release", 64'(mem_if.memreq_rdy), 64'd3);
        applyStimulus(0, 3'd0, 32'h50, 2'd0, 32'h0, 1'b1);
        waitDrain(0);

`ifdef VC_TEST_MEM_STATS_EN
        checkOutput("num_reqs", num_reqs, {32'(acc_count[1]), 32'(acc_count[0])});
`else
        checkOutput("num_reqs", num_reqs, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
